abc_feeder: RTL and testbench

- Upstream feeder for the `top` datapath, which computes y = a·b·cos(2πc/2^12)/(a+d)/2^12.
- Serially loads the 12-bit divisor offset d into `top` through its `e` input, then issues buffered (a,b,c) operand triples one per cycle from a small FIFO.
- Tracks each issued triple through `top`'s latency and captures y with a matching valid strobe, so downstream logic never counts cycles.

---
 rtl/abc_feeder_pkg.sv | 23 ++
 rtl/abc_fifo.sv | 78 +++++++
 rtl/abc_feeder.sv | 163 ++++++++++++++++
 tb/tb_abc_feeder.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/abc_feeder_pkg.sv
// abc_feeder_pkg
//   Shared constants and types for the abc_feeder slice: the operand width,
//   the result width produced by the downstream `top` datapath, the default
//   operand FIFO geometry and the feeder FSM state encoding.
package abc_feeder_pkg;

  // Operand width of a, b, c and the serially loaded divisor offset d.
  localparam int W = 12;
  // Width of the result y coming back from `top`.
  localparam int YW = W + 1;
  // Default operand FIFO depth and the pointer width that goes with it.
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // Bit counter width for walking the W bits of d during a load.
  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/abc_fifo.sv
// abc_fifo
//   Synchronous FIFO holding packed (a,b,c) operand triples for the feeder.
//   No bypass: data pushed this cycle is visible on pop_data after the edge.
//   Ports:
//     clk, rst_n          clock and asynchronous active-low reset
//     push, push_data     write request and data (ignored while full)
//     pop                 read request (ignored while empty)
//     pop_data            head-of-queue entry, valid while !empty
//     full, empty         occupancy flags, decoded from the count register
module abc_fifo
  import abc_feeder_pkg::*;
#(
  parameter int WIDTH = 3 * W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count guards against reading stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/abc_feeder.sv
// abc_feeder
//   Upstream feeder for the `top` datapath. Shifts the divisor offset d into
//   `top` serially on `e` (MSB first), then issues buffered (a,b,c) triples
//   one per cycle and re-times `top`'s result y into a y_valid/y_out pair.
//   Ports:
//     clk, rst_n             clock and asynchronous active-low reset
//     cfg_d, cfg_start       d value and one-cycle load request
//     cfg_busy               high while d is being shifted out
//     in_valid/in_ready      operand triple handshake (in_ready = FIFO not full)
//     in_a, in_b, in_c       offered operand triple
//     a, b, c, e             registered drive into `top`
//     op_valid               a/b/c carry a freshly issued triple this cycle
//     y_in                   result from `top`
//     y_valid, y_out         captured result, one pulse per issued triple
module abc_feeder
  import abc_feeder_pkg::*;
#(
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int PIPE_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  cfg_d,
  input  logic          cfg_start,
  output logic          cfg_busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [W-1:0]  in_c,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  output logic [W-1:0]  c,
  output logic          e,
  output logic          op_valid,
  input  logic [YW-1:0] y_in,
  output logic          y_valid,
  output logic [YW-1:0] y_out
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic               e_q, e_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, c_q, c_d;
  logic               op_valid_q, op_valid_d;
  logic [PIPE_LAT-1:0] tag_q, tag_d;
  logic               y_valid_q, y_valid_d;
  logic [YW-1:0]      y_out_q, y_out_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [3*W-1:0]     fifo_rd_data;

  abc_fifo #(
    .WIDTH(3 * W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data ({in_a, in_b, in_c}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Issue only happens from RUN; the edge that leaves RUN for a reload still
  // issues, so a triple already at the FIFO head is never held back.
  assign fifo_pop = (state_q == RUN) && !fifo_empty;
  assign in_ready = !fifo_full;

  assign cfg_busy = (state_q == LOAD);
  assign e        = e_q;
  assign a        = a_q;
  assign b        = b_q;
  assign c        = c_q;
  assign op_valid = op_valid_q;
  assign y_valid  = y_valid_q;
  assign y_out    = y_out_q;

  // Load sequencing: d is shifted left so the bit for the next cycle always
  // sits at a fixed position, and e is registered one bit ahead of the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    e_d     = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (cfg_start) begin
          state_d = LOAD;
          shreg_d = cfg_d;
          cnt_d   = '0;
          e_d     = cfg_d[W-1];
        end
      end
      LOAD: begin
        shreg_d = shreg_q << 1;
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          e_d   = shreg_q[W-2];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand issue and result tracking: op_valid enters a PIPE_LAT-deep tag
  // pipe whose tail marks the cycle in which y_in belongs to an issued triple.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    op_valid_d = fifo_pop;
    if (fifo_pop) begin
      {a_d, b_d, c_d} = fifo_rd_data;
    end
    tag_d    = '0;
    tag_d[0] = op_valid_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    y_valid_d = tag_q[PIPE_LAT-1];
    y_out_d   = tag_q[PIPE_LAT-1] ? y_in : y_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      e_q        <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      op_valid_q <= 1'b0;
      tag_q      <= '0;
      y_valid_q  <= 1'b0;
      y_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      e_q        <= e_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      op_valid_q <= op_valid_d;
      tag_q      <= tag_d;
      y_valid_q  <= y_valid_d;
      y_out_q    <= y_out_d;
    end
  end

endmodule

// File: tb/tb_abc_feeder.sv
// tb_abc_feeder
//   Self-checking bench for abc_feeder (DEPTH=4, PIPE_LAT=1). A stand-in for
//   `top` turns a/b/c into y_in one edge later; a transaction-level model of
//   the feeder runs alongside and is compared every cycle, in addition to
//   table-driven load/stream vectors and hand-built corner sequences.
module tb_abc_feeder;
  import abc_feeder_pkg::*;

  localparam int DEPTH    = 4;
  localparam int PIPE_LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  cfg_d;
  logic          cfg_start;
  logic          cfg_busy;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a, in_b, in_c;
  logic [W-1:0]  a, b, c;
  logic          e;
  logic          op_valid;
  logic [YW-1:0] y_in;
  logic          y_valid;
  logic [YW-1:0] y_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  abc_feeder #(
    .DEPTH(DEPTH),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_d     (cfg_d),
    .cfg_start (cfg_start),
    .cfg_busy  (cfg_busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .a         (a),
    .b         (b),
    .c         (c),
    .e         (e),
    .op_valid  (op_valid),
    .y_in      (y_in),
    .y_valid   (y_valid),
    .y_out     (y_out)
  );

  // Stand-in for `top`: any pass-through-checkable function of the operands.
  function automatic logic [YW-1:0] top_fn(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                           input logic [W-1:0] fc);
    return {1'b0, fa} + {1'b0, (fb ^ fc)};
  endfunction

  // One-edge-latency `top` model feeding y_in.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_in <= '0;
    else        y_in <= top_fn(a, b, c);
  end

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } trip_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [YW-1:0] y;
  } strm_vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] bits;
  } load_vec_t;

  typedef enum {M_IDLE, M_LOAD, M_RUN} mstate_t;

  // Transaction-level model state; holds the expected post-edge outputs.
  mstate_t       m_state;
  int            m_cnt;
  logic [W-1:0]  m_d;
  trip_t         m_q[$];
  logic          m_op;
  trip_t         m_cur;
  logic          m_tag;
  trip_t         m_tag_t;
  logic          m_yv;
  logic [YW-1:0] m_y;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                               input logic [W-1:0] ic, input logic st, input logic [W-1:0] d);
    in_valid  = v;
    in_a      = ia;
    in_b      = ib;
    in_c      = ic;
    cfg_start = st;
    cfg_d     = d;
  endtask

  task automatic resetModel();
    m_state = M_IDLE;
    m_cnt   = 0;
    m_d     = '0;
    m_q.delete();
    m_op    = 1'b0;
    m_cur   = '0;
    m_tag   = 1'b0;
    m_tag_t = '0;
    m_yv    = 1'b0;
    m_y     = '0;
  endtask

  task automatic compareModel();
    logic exp_e;
    exp_e = (m_state == M_LOAD) ? m_d[W-1-m_cnt] : 1'b0;
    checkOutput("mdl_busy", cfg_busy, (m_state == M_LOAD));
    checkOutput("mdl_e", e, exp_e);
    checkOutput("mdl_in_ready", in_ready, (m_q.size() < DEPTH));
    checkOutput("mdl_op_valid", op_valid, m_op);
    checkOutput("mdl_a", a, m_cur.a);
    checkOutput("mdl_b", b, m_cur.b);
    checkOutput("mdl_c", c, m_cur.c);
    checkOutput("mdl_y_valid", y_valid, m_yv);
    checkOutput("mdl_y_out", y_out, m_y);
  endtask

  // Advance the model with the inputs now applied, take one clock edge,
  // then compare the DUT against the model 1 ns after the edge.
  task automatic cycle();
    logic push, pop;
    if (!rst_n) begin
      resetModel();
    end else begin
      push = in_valid && (m_q.size() < DEPTH);
      pop  = (m_state == M_RUN) && (m_q.size() > 0);
      m_yv = m_tag;
      if (m_tag) m_y = top_fn(m_tag_t.a, m_tag_t.b, m_tag_t.c);
      m_tag   = m_op;
      m_tag_t = m_cur;
      m_op    = pop;
      if (pop) m_cur = m_q.pop_front();
      if (push) m_q.push_back(trip_t'({in_a, in_b, in_c}));
      case (m_state)
        M_IDLE, M_RUN: begin
          if (cfg_start) begin
            m_state = M_LOAD;
            m_d     = cfg_d;
            m_cnt   = 0;
          end
        end
        M_LOAD: begin
          if (m_cnt == W - 1) m_state = M_RUN;
          else                m_cnt++;
        end
        default: m_state = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    compareModel();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_a"}, a, 0);
    checkOutput({tag, "_b"}, b, 0);
    checkOutput({tag, "_c"}, c, 0);
    checkOutput({tag, "_e"}, e, 0);
    checkOutput({tag, "_op_valid"}, op_valid, 0);
    checkOutput({tag, "_busy"}, cfg_busy, 0);
    checkOutput({tag, "_y_valid"}, y_valid, 0);
    checkOutput({tag, "_y_out"}, y_out, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    load_vec_t loads[2];
    strm_vec_t strm[3];
    logic [W-1:0] fa[5], fb[5], fc[5];
    logic [W-1:0] ra[4], rb[4], rc[4];
    int idx, acc5;
    int busy_cnt, ops, yvs, ops_in_load;
    logic accepted;

    loads[0] = '{d: 12'hA5C, bits: 12'b1010_0101_1100};
    loads[1] = '{d: 12'h3F1, bits: 12'b0011_1111_0001};
    strm[0]  = '{a: 12'd100,  b: 12'd200,  c: 12'd0,    y: 13'd300};
    strm[1]  = '{a: 12'd4095, b: 12'd4095, c: 12'd1024, y: 13'd7166};
    strm[2]  = '{a: 12'd1,    b: 12'd1,    c: 12'd2048, y: 13'd2050};
    for (int i = 0; i < 5; i++) begin
      fa[i] = W'($urandom_range(0, 4095));
      fb[i] = W'($urandom_range(0, 4095));
      fc[i] = W'($urandom_range(0, 4095));
    end
    for (int i = 0; i < 4; i++) begin
      ra[i] = W'(12'h100 + i);
      rb[i] = W'(12'h200 + 3 * i);
      rc[i] = W'(12'h7F0 + 5 * i);
    end

    // Power-on reset.
    rst_n = 1'b0;
    applyStimulus(0, '0, '0, '0, 0, '0);
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkReset("por");
    rst_n = 1'b1;
    cycle();

    // d loads from IDLE and then from RUN; e must follow the hand-written bits.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, '0, '0, '0, 1, loads[k].d);
      cycle();
      applyStimulus(0, '0, '0, '0, 0, '0);
      for (int i = 0; i < W; i++) begin
        checkOutput("load_busy", cfg_busy, 1);
        checkOutput("load_e", e, loads[k].bits[W-1-i]);
        cycle();
      end
      checkOutput("load_done_busy", cfg_busy, 0);
      checkOutput("load_done_e", e, 0);
    end

    // Streaming three triples back to back in RUN.
    for (int k = 0; k < 6; k++) begin
      if (k < 3) applyStimulus(1, strm[k].a, strm[k].b, strm[k].c, 0, '0);
      else       applyStimulus(0, '0, '0, '0, 0, '0);
      cycle();
      checkOutput("strm_op_valid", op_valid, (k >= 1 && k <= 3));
      if (k >= 1 && k <= 3) begin
        checkOutput("strm_a", a, strm[k-1].a);
        checkOutput("strm_b", b, strm[k-1].b);
        checkOutput("strm_c", c, strm[k-1].c);
      end
      checkOutput("strm_y_valid", y_valid, (k >= 3));
      if (k >= 3) checkOutput("strm_y_out", y_out, strm[k-3].y);
    end

    // Empty FIFO in RUN: outputs quiet, operands hold the last triple.
    for (int k = 0; k < 10; k++) begin
      cycle();
      checkOutput("idle_op_valid", op_valid, 0);
      checkOutput("idle_y_valid", y_valid, 0);
      checkOutput("idle_a", a, strm[2].a);
      checkOutput("idle_b", b, strm[2].b);
      checkOutput("idle_c", c, strm[2].c);
    end

    // FIFO fills during a load; the fifth triple waits for the first pop.
    applyStimulus(0, '0, '0, '0, 1, 12'h123);
    cycle();
    idx  = 0;
    acc5 = -1;
    for (int k = 0; k < 26; k++) begin
      if (idx < 5) applyStimulus(1, fa[idx], fb[idx], fc[idx], 0, '0);
      else         applyStimulus(0, '0, '0, '0, 0, '0);
      accepted = (idx < 5) && (m_q.size() < DEPTH);
      cycle();
      if (accepted) begin
        if (idx == 4) acc5 = k;
        idx++;
      end
    end
    checkOutput("full_5th_accept_cycle", acc5, 13);

    // Reload from RUN with triples queued; cfg_start inside LOAD is ignored.
    applyStimulus(0, '0, '0, '0, 1, 12'hC3A);
    cycle();
    busy_cnt    = 0;
    ops         = 0;
    yvs         = 0;
    ops_in_load = 0;
    for (int k = 0; k < 36; k++) begin
      applyStimulus((k < 4), ra[k % 4], rb[k % 4], rc[k % 4], (k == 6) || (k == 13),
                    (k == 13) ? 12'h5A5 : 12'hFFF);
      cycle();
      if (cfg_busy) busy_cnt++;
      if (op_valid) ops++;
      if (y_valid) yvs++;
      if (cfg_busy && op_valid) ops_in_load++;
    end
    applyStimulus(0, '0, '0, '0, 0, '0);
    checkOutput("reload_busy_cycles", busy_cnt, 23);
    checkOutput("reload_issues", ops, 4);
    checkOutput("reload_results", yvs, 4);
    checkOutput("reload_issue_in_load", ops_in_load, 1);

    // Reset asserted in the middle of a load (bit 5).
    applyStimulus(0, '0, '0, '0, 1, 12'hA5C);
    cycle();
    applyStimulus(0, '0, '0, '0, 0, '0);
    repeat (5) cycle();
    rst_n = 1'b0;
    #2;
    checkReset("mid_load");
    resetModel();
    @(posedge clk);
    #1;
    checkReset("held");
    rst_n = 1'b1;
    cycle();
    checkOutput("post_rst_busy", cfg_busy, 0);
    checkOutput("post_rst_e", e, 0);
    applyStimulus(1, 12'h011, 12'h022, 12'h033, 0, '0);
    cycle();
    applyStimulus(0, '0, '0, '0, 0, '0);
    repeat (3) cycle();
    checkOutput("idle_no_issue", op_valid, 0);
    checkOutput("idle_no_load", cfg_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
